// File: rtl/ram2_if.sv
// Access bundle for ram2: write port, read port, clear request and status.
interface ram2_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BYTE_WIDTH = 8
);
   localparam int NB = DATA_WIDTH / BYTE_WIDTH;

   logic                  clr;
   logic                  we;
   logic [NB-1:0]         be;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  re;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_valid;
   logic                  busy;

   modport master (
      output clr, we, be, w_addr, i_data, re, r_addr,
      input  o_data, o_valid, busy
   );

   modport slave (
      input  clr, we, be, w_addr, i_data, re, r_addr,
      output o_data, o_valid, busy
   );
endinterface

// File: rtl/ram2.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle read latency and a
// self-clearing sequencer that zeroes every word after reset or on request.
//
// state | meaning
// CLEAR | sweeping cnt_q over all words writing zero; user accesses ignored
// READY | user reads/writes accepted; clr returns to CLEAR
module ram2 #(
   parameter int ADDR_WIDTH   = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int BYTE_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input logic   clk,
   input logic   rst,
   ram2_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

   if ((READ_LATENCY != 1 && READ_LATENCY != 2) || (DATA_WIDTH % BYTE_WIDTH != 0)) begin : g_param_err
      $error("ram2: READ_LATENCY must be 1 or 2 and DATA_WIDTH a multiple of BYTE_WIDTH");
   end

   typedef enum logic {CLEAR, READY} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  busy_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  wr_en;
   logic [NB-1:0]         wr_be;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_fire;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] o_data_q;
   logic                  o_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == CLEAR);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_be   = '0;
      wr_addr = bus.w_addr;
      wr_data = bus.i_data;
      rd_fire = 1'b0;
      case (state_q)
         CLEAR: begin
            wr_en   = 1'b1;
            wr_be   = '1;
            wr_addr = cnt_q;
            wr_data = '0;
            cnt_d   = cnt_q + 1'b1;
            if (&cnt_q) state_d = READY;
         end
         READY: begin
            if (bus.clr) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else begin
               wr_en   = bus.we;
               wr_be   = bus.be;
               rd_fire = bus.re;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // Array has no reset; the clear sequencer is what initialises it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < NB; k++) begin
            if (wr_be[k]) mem[wr_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   assign rd_word = mem[bus.r_addr];

   if (READ_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
         end else begin
            o_valid_q <= rd_fire;
            if (rd_fire) o_data_q <= rd_word;
         end
      end
   end else begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_data_q;
      logic                  s1_valid_q;

      // Stage 1 keeps advancing in CLEAR so reads issued before clr complete.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            o_data_q   <= '0;
            o_valid_q  <= 1'b0;
         end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) s1_data_q <= rd_word;
            o_valid_q <= s1_valid_q;
            if (s1_valid_q) o_data_q <= s1_data_q;
         end
      end
   end

   assign bus.o_data  = o_data_q;
   assign bus.o_valid = o_valid_q;
   assign bus.busy    = busy_q;
endmodule

// File: tb/tb_ram2.sv
// Self-checking bench for ram2: a latency-1 and a latency-2 instance driven
// with identical stimulus and compared against a word-array reference model.
module tb_ram2;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [15:0] model [16];

   ram2_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8)) if1 ();
   ram2_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8)) if2 ();

   ram2 #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .READ_LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .bus(if1.slave)
   );
   ram2 #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .READ_LATENCY(2)) u2 (
      .clk(clk), .rst(rst), .bus(if2.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic w, input logic [1:0] b, input logic [3:0] wa,
                        input logic [15:0] wd, input logic r, input logic [3:0] ra);
      if1.clr = c; if1.we = w; if1.be = b; if1.w_addr = wa; if1.i_data = wd; if1.re = r; if1.r_addr = ra;
      if2.clr = c; if2.we = w; if2.be = b; if2.w_addr = wa; if2.i_data = wd; if2.re = r; if2.r_addr = ra;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0);
   endtask

   task automatic model_write(input logic [3:0] a, input logic [1:0] b, input logic [15:0] d);
      if (b[0]) model[a][7:0]  = d[7:0];
      if (b[1]) model[a][15:8] = d[15:8];
   endtask

   task automatic write_word(input logic [3:0] a, input logic [1:0] b, input logic [15:0] d);
      drive(1'b0, 1'b1, b, a, d, 1'b0, 4'd0);
      cyc();
      model_write(a, b, d);
      idle();
   endtask

   task automatic test_reset();
      int n;
      idle();
      rst = 1'b1;
      cyc();
      cyc();
      total++;
      if (if1.busy !== 1'b1 || if1.o_valid !== 1'b0 || if1.o_data !== 16'h0 ||
          if2.busy !== 1'b1 || if2.o_valid !== 1'b0 || if2.o_data !== 16'h0) begin
         bad++;
         $display("FAIL reset_values: busy=%b/%b valid=%b/%b data=%h/%h, want busy=1 valid=0 data=0",
                  if1.busy, if2.busy, if1.o_valid, if2.o_valid, if1.o_data, if2.o_data);
      end
      rst = 1'b0;
      n = 0;
      while (if1.busy === 1'b1 && n < 40) begin
         n++;
         cyc();
      end
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL reset_busy_len: got %0d cycles, want 16", n);
      end
      for (int i = 0; i < 16; i++) model[i] = 16'h0;
      for (int a = 0; a < 16; a++) begin
         drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'(a));
         cyc();
         total++;
         if (if1.o_valid !== 1'b1 || if1.o_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_read_zero a=%0d: valid=%b data=%h, want 1/0000", a, if1.o_valid, if1.o_data);
         end
      end
      idle();
      cyc();
   endtask

   task automatic test_full_rw();
      int vrun;
      for (int a = 0; a < 16; a++) write_word(4'(a), 2'b11, 16'h1000 + 16'(a));
      vrun = 0;
      for (int i = 0; i < 18; i++) begin
         drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, (i < 16), 4'(i));
         cyc();
         if (if1.o_valid === 1'b1) vrun++;
         if (i < 16) begin
            total++;
            if (if1.o_valid !== 1'b1 || if1.o_data !== model[i]) begin
               bad++;
               $display("FAIL full_rw_lat1 a=%0d: valid=%b data=%h, want 1/%h", i, if1.o_valid, if1.o_data, model[i]);
            end
         end else if (i == 16) begin
            total++;
            if (if1.o_valid !== 1'b0 || if1.o_data !== 16'h100F) begin
               bad++;
               $display("FAIL full_rw_hold: valid=%b data=%h, want 0/100f", if1.o_valid, if1.o_data);
            end
         end
         if (i >= 1 && i <= 16) begin
            total++;
            if (if2.o_valid !== 1'b1 || if2.o_data !== model[i-1]) begin
               bad++;
               $display("FAIL full_rw_lat2 a=%0d: valid=%b data=%h, want 1/%h", i-1, if2.o_valid, if2.o_data, model[i-1]);
            end
         end
      end
      total++;
      if (vrun != 16) begin
         bad++;
         $display("FAIL full_rw_valid_run: got %0d, want 16", vrun);
      end
      idle();
   endtask

   task automatic test_byte_en();
      write_word(4'd3, 2'b11, 16'hAABB);
      write_word(4'd3, 2'b01, 16'h1122);
      drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd3);
      cyc();
      total++;
      if (if1.o_data !== 16'hAA22 || model[3] !== 16'hAA22) begin
         bad++;
         $display("FAIL byte_en_low: data=%h, want aa22", if1.o_data);
      end
      idle();
      write_word(4'd3, 2'b00, 16'h3344);
      drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd3);
      cyc();
      idle();
      total++;
      if (if1.o_valid !== 1'b1 || if1.o_data !== 16'hAA22) begin
         bad++;
         $display("FAIL byte_en_none: valid=%b data=%h, want 1/aa22", if1.o_valid, if1.o_data);
      end
      cyc();
      total++;
      if (if2.o_valid !== 1'b1 || if2.o_data !== 16'hAA22) begin
         bad++;
         $display("FAIL byte_en_lat2: valid=%b data=%h, want 1/aa22", if2.o_valid, if2.o_data);
      end
   endtask

   task automatic test_collision();
      write_word(4'd5, 2'b11, 16'h0055);
      drive(1'b0, 1'b1, 2'b11, 4'd5, 16'h7777, 1'b1, 4'd5);
      cyc();
      model_write(4'd5, 2'b11, 16'h7777);
      total++;
      if (if1.o_data !== 16'h0055) begin
         bad++;
         $display("FAIL collision_old: data=%h, want 0055", if1.o_data);
      end
      drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd5);
      cyc();
      idle();
      total++;
      if (if1.o_data !== 16'h7777 || if2.o_data !== 16'h0055) begin
         bad++;
         $display("FAIL collision_new: lat1=%h lat2=%h, want 7777/0055", if1.o_data, if2.o_data);
      end
      cyc();
      total++;
      if (if2.o_data !== 16'h7777) begin
         bad++;
         $display("FAIL collision_new_lat2: data=%h, want 7777", if2.o_data);
      end
   endtask

   task automatic test_random();
      logic        w, r, pr;
      logic [1:0]  b;
      logic [3:0]  wa, ra;
      logic [15:0] wd, e, pe;
      idle();
      cyc();
      pr = 1'b0;
      pe = 16'h0;
      for (int i = 0; i < 200; i++) begin
         w  = 1'($urandom_range(0, 1));
         r  = 1'($urandom_range(0, 1));
         b  = 2'($urandom_range(0, 3));
         wa = 4'($urandom_range(0, 15));
         ra = 4'($urandom_range(0, 15));
         wd = 16'($urandom);
         e  = model[ra];
         drive(1'b0, w, b, wa, wd, r, ra);
         cyc();
         if (w) model_write(wa, b, wd);
         total++;
         if (if1.o_valid !== r || (r && if1.o_data !== e) ||
             if2.o_valid !== pr || (pr && if2.o_data !== pe)) begin
            bad++;
            $display("FAIL random i=%0d: lat1 %b/%h want %b/%h, lat2 %b/%h want %b/%h",
                     i, if1.o_valid, if1.o_data, r, e, if2.o_valid, if2.o_data, pr, pe);
         end
         pr = r;
         pe = e;
      end
      idle();
      cyc();
   endtask

   task automatic test_lat2_clr();
      int n;
      write_word(4'd2, 2'b11, 16'h1234);
      drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd2);
      cyc();
      total++;
      if (if1.o_valid !== 1'b1 || if1.o_data !== 16'h1234) begin
         bad++;
         $display("FAIL clr_lat1_read: valid=%b data=%h, want 1/1234", if1.o_valid, if1.o_data);
      end
      drive(1'b1, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0);
      cyc();
      for (int i = 0; i < 16; i++) model[i] = 16'h0;
      total++;
      if (if2.o_valid !== 1'b1 || if2.o_data !== 16'h1234 || if2.busy !== 1'b1) begin
         bad++;
         $display("FAIL clr_inflight: valid=%b data=%h busy=%b, want 1/1234/1", if2.o_valid, if2.o_data, if2.busy);
      end
      n = 0;
      while (if2.busy === 1'b1 && n < 40) begin
         n++;
         drive(1'b0, 1'b1, 2'b11, 4'd2, 16'hFFFF, 1'b1, 4'd2);
         cyc();
         total++;
         if (if1.o_valid !== 1'b0 || if2.o_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_busy_valid: valid=%b/%b, want 0/0", if1.o_valid, if2.o_valid);
         end
      end
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL clr_busy_len: got %0d cycles, want 16", n);
      end
      drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd2);
      cyc();
      idle();
      cyc();
      total++;
      if (if1.o_data !== model[2] || if2.o_valid !== 1'b1 || if2.o_data !== model[2]) begin
         bad++;
         $display("FAIL clr_zeroed: lat1=%h lat2=%b/%h, want 0000 and 1/0000", if1.o_data, if2.o_valid, if2.o_data);
      end
   endtask

   task automatic test_rst_mid_clear();
      int n;
      write_word(4'd9, 2'b11, 16'hBEEF);
      drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd9);
      cyc();
      idle();
      cyc();
      total++;
      if (if1.o_data !== 16'hBEEF || if2.o_data !== 16'hBEEF) begin
         bad++;
         $display("FAIL rmc_setup: data=%h/%h, want beef", if1.o_data, if2.o_data);
      end
      drive(1'b1, 1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 4'd0);
      cyc();
      idle();
      for (int i = 0; i < 7; i++) cyc();
      rst = 1'b1;
      #1;
      total++;
      if (if1.busy !== 1'b1 || if1.o_valid !== 1'b0 || if1.o_data !== 16'h0 ||
          if2.busy !== 1'b1 || if2.o_valid !== 1'b0 || if2.o_data !== 16'h0) begin
         bad++;
         $display("FAIL rmc_async: busy=%b/%b valid=%b/%b data=%h/%h, want 1/0/0",
                  if1.busy, if2.busy, if1.o_valid, if2.o_valid, if1.o_data, if2.o_data);
      end
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 16'h0;
      n = 0;
      while (if1.busy === 1'b1 && n < 40) begin
         n++;
         cyc();
      end
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL rmc_busy_len: got %0d cycles, want 16", n);
      end
      drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd9);
      cyc();
      idle();
      total++;
      if (if1.o_valid !== 1'b1 || if1.o_data !== model[9]) begin
         bad++;
         $display("FAIL rmc_zeroed: valid=%b data=%h, want 1/0000", if1.o_valid, if1.o_data);
      end
      cyc();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle();
      test_reset();
      test_full_rw();
      test_byte_en();
      test_collision();
      test_random();
      test_lat2_clr();
      test_rst_mid_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ram2.md
# ram2

Parametrised simple dual-port synchronous RAM, the successor of the single-port `ram1`. It adds independent write and read ports, per-byte write enables and a selectable read latency of 1 or 2 cycles. A built-in clear sequencer zeroes every location after reset or on request. It is the generic on-chip storage block for buffers and register files in the design.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: address width; depth `DEPTH = 1<<ADDR_WIDTH`.
- `DATA_WIDTH`, 8: word width; must be an integer multiple of `BYTE_WIDTH`.
- `BYTE_WIDTH`, 8: byte-lane width; `NB = DATA_WIDTH/BYTE_WIDTH` lanes.
- `READ_LATENCY`, 1: cycles from the read request to `o_data` valid; legal values are 1 and 2.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `clr`  in  1  synchronous pulse that restarts the clear sequence.
- `we`  in  1  write request.
- `be`  in  NB  byte enables; lane k covers `i_data[k*BYTE_WIDTH +: BYTE_WIDTH]`.
- `w_addr`  in  ADDR_WIDTH  write address.
- `i_data`  in  DATA_WIDTH  write data.
- `re`  in  1  read request.
- `r_addr`  in  ADDR_WIDTH  read address.
- `o_data`  out  DATA_WIDTH  read data.
- `o_valid`  out  1  one-cycle strobe marking `o_data` as valid.
- `busy`  out  1  clear sequence is in progress; user accesses are ignored.

## Operation
- The state machine has two states, CLEAR and READY.
- When `rst` is asserted, the block asynchronously enters CLEAR with clear counter `cnt=0`.
  - Reset values: `busy=1`, `o_data=0`, `o_valid=0`, all read pipeline registers 0.
  - Memory array contents are not reset directly.
- CLEAR state:
  - Every cycle: `mem[cnt]<=0` and `cnt<=cnt+1`.
  - On the cycle that writes `cnt==DEPTH-1`, the next state is READY.
  - `we`, `re` and `clr` are ignored in CLEAR: no write, and no `o_valid`.
- READY state, `busy=0`:
  - Write: if `we`, then for each k with `be[k]=1`, lane k of `mem[w_addr]` takes lane k of `i_data`. Lanes with `be[k]=0` are unchanged. `we` with `be=0` is a no-op.
  - Read: if `re`, `mem[r_addr]` is captured and `o_valid` is set for one cycle after `READ_LATENCY` cycles.
  - Read and write at the same address in the same cycle: the read returns the old data (read-first). The written value is visible to reads from the next cycle onward.
  - When no read completes, `o_data` holds its last value and `o_valid=0`.
  - Back-to-back `re` is supported every cycle at full throughput.
- `clr` in READY: the next state is CLEAR with `cnt=0`.
  - A write or read presented in the same cycle as `clr` is ignored.
  - Reads already in flight in the latency-2 pipeline still complete with their `o_valid`.
- `rst` asserted at any point, mid-clear or mid-read, aborts everything: in-flight reads are dropped and the clear restarts from address 0.
- No reset or clear state drives X on outputs; the memory is fully zero after any completed clear.
- Synthesis check: `READ_LATENCY` other than 1 or 2, or a `DATA_WIDTH` that is not a multiple of `BYTE_WIDTH`, is rejected with an `$error`.

## Timing
- Clear duration: exactly `DEPTH` cycles.
  - After `rst` deasserts, `busy` is high on the first `DEPTH` rising edges and low from edge `DEPTH+1` on.
  - After a `clr` pulse sampled at edge N, `busy=1` from N through N+DEPTH and 0 after.
- Read latency 1: `re` sampled at edge N gives `o_data`/`o_valid` updated at edge N+1.
- Read latency 2: `re` sampled at edge N gives the result at edge N+2. The intermediate stage carries both the data and a valid bit.
- Write latency: data written at edge N is readable by a `re` sampled at edge N+1.
- `busy` is a registered output; it changes only on `clk` edges or asynchronously on `rst`.

## Test plan
Configuration for all scenarios unless noted: `ADDR_WIDTH=4`, `DATA_WIDTH=16`, `BYTE_WIDTH=8`.

1. Reset and clear: pulse `rst`.
   - `busy=1` for exactly 16 edges, then 0.
   - Read all 16 addresses: `o_data=0x0000` each time, with `o_valid` on each.
2. Full write/read, latency 1: write `addr+0x1000` to addresses 0–15 with `be=2'b11`, then read 0–15 back to back.
   - Reads return `0x1000`..`0x100F` one cycle after each `re`.
   - `o_valid` is high for 16 consecutive cycles.
3. Byte enables:
   - Write `0xAABB` to address 3 with `be=2'b11`.
   - Write `0x1122` to address 3 with `be=2'b01`.
   - Read address 3: `0xAA22`.
   - Write `0x3344` to address 3 with `be=2'b00`; read again: still `0xAA22`.
4. Collision: address 5 holds `0x0055`; issue `we` of `0x7777` and `re` to address 5 in the same cycle.
   - That read returns `0x0055`.
   - A read of address 5 on the next cycle returns `0x7777`.
5. Latency 2 with clr: set `READ_LATENCY=2`.
   - Issue `re` to address 2 (holding `0x1234`) and pulse `clr` on the following cycle.
   - `o_data=0x1234` with `o_valid` two cycles after `re`.
   - `busy` is then high for 16 cycles.
   - A `we` during `busy` is ignored, and address 2 reads `0x0000` afterwards.
6. Reset mid-clear: assert `rst` 7 cycles into a clear.
   - Outputs return to 0 immediately.
   - `busy` stays high for 16 cycles after `rst` deasserts.
